// File: rtl/button_counter_gen.sv
// button_counter_gen: two debounced push-buttons step an up/down counter with load, wrap/saturate and status flags.
// Optional AUTO_REPEAT_EN adds a per-button auto-repeat timer while a button stays held.
module button_counter_gen #(
  parameter int WIDTH = 4,
  parameter int MAX_VALUE = 2**WIDTH-1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SATURATE = 0,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap_pulse
);
  localparam int SW = $clog2(DEBOUNCE_CYCLES+1);
  localparam logic [SW-1:0] STAB_END = SW'(DEBOUNCE_CYCLES-1);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VALUE);
  localparam bit SAT = (SATURATE != 0);
  logic [1:0] raw, ev;
  logic [WIDTH-1:0] count_n, lv;
  logic wrap_n;
  assign raw = {btn_down, btn_up};
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic s1, s2, db, press;
    logic [SW-1:0] stab;
    // Fires on the same edge that db is about to rise, so the count moves with it.
    assign press = s2 & ~db & (stab == STAB_END);
    always_ff @(posedge clk)
      if (reset) {s1, s2, db, stab} <= '0;
      else begin
        s1 <= raw[b];
        s2 <= s1;
        if (s2 == db) stab <= '0;
        else if (stab == STAB_END) begin
          db <= s2;
          stab <= '0;
        end
        else stab <= stab + SW'(1);
      end
`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES+1);
    localparam logic [RW-1:0] REP_END = RW'(REPEAT_CYCLES-1);
    logic [RW-1:0] rep;
    logic rep_ev;
    assign rep_ev = db & (rep == REP_END);
    always_ff @(posedge clk)
      if (reset || press || !db) rep <= '0;
      else rep <= rep_ev ? '0 : rep + RW'(1);
    assign ev[b] = press | rep_ev;
`else
    assign ev[b] = press;
`endif
  end
  assign lv = (load_value > MAX) ? MAX : load_value;
  always_comb begin
    count_n = count;
    wrap_n = 1'b0;
    if (load) count_n = lv;
    else if (ev == 2'b01) begin
      count_n = (count != MAX) ? count + WIDTH'(1) : (SAT ? count : '0);
      wrap_n = (count == MAX) & ~SAT;
    end
    else if (ev == 2'b10) begin
      count_n = (count != '0) ? count - WIDTH'(1) : (SAT ? count : MAX);
      wrap_n = (count == '0) & ~SAT;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      count <= '0;
      wrap_pulse <= 1'b0;
    end
    else begin
      count <= count_n;
      wrap_pulse <= wrap_n;
    end
  assign at_max = (count == MAX);
  assign at_min = (count == '0);
endmodule

// File: tb/tb_button_counter_gen.sv
// tb_button_counter_gen: directed scoreboard bench; three variants (wrap, saturate, MAX_VALUE=10) share one stimulus.
module tb_button_counter_gen;
  logic clk = 1'b0, reset = 1'b1, btn_up = 1'b0, btn_down = 1'b0, load = 1'b0;
  logic [3:0] load_value = '0;
  logic [3:0] c0, c1, c2;
  logic mx0, mx1, mx2, mn0, mn1, mn2, w0, w1, w2;
  int tests = 0, fails = 0;
  typedef struct {
    string tag;
    logic [3:0] c0, c1, c2;
    logic [2:0] w;
  } exp_t;
  exp_t sb[$];
  logic [3:0] e0 = '0, e1 = '0, e2 = '0;

  always #5 clk = ~clk;

  button_counter_gen dut (.clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .load(load),
    .load_value(load_value), .count(c0), .at_max(mx0), .at_min(mn0), .wrap_pulse(w0));
  button_counter_gen #(.SATURATE(1)) dut_s (.clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .load(load), .load_value(load_value), .count(c1), .at_max(mx1), .at_min(mn1), .wrap_pulse(w1));
  button_counter_gen #(.MAX_VALUE(10)) dut_m (.clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .load(load), .load_value(load_value), .count(c2), .at_max(mx2), .at_min(mn2), .wrap_pulse(w2));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] a, b, c, input logic [2:0] w);
    exp_t e;
    e.tag = tag; e.c0 = a; e.c1 = b; e.c2 = c; e.w = w;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    tests--;
    e = sb.pop_front();
    chk({e.tag, ".count0"}, 8'(c0), 8'(e.c0));
    chk({e.tag, ".count1"}, 8'(c1), 8'(e.c1));
    chk({e.tag, ".count2"}, 8'(c2), 8'(e.c2));
    chk({e.tag, ".wrap"}, 8'({w2, w1, w0}), 8'(e.w));
    chk({e.tag, ".at_max"}, 8'({mx2, mx1, mx0}), 8'({e.c2 == 4'd10, e.c1 == 4'd15, e.c0 == 4'd15}));
    chk({e.tag, ".at_min"}, 8'({mn2, mn1, mn0}), 8'({e.c2 == 4'd0, e.c1 == 4'd0, e.c0 == 4'd0}));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press held from the next edge: unchanged on edge 5, new value on edge 6, pulse gone one edge later.
  task automatic press(input string tag, input logic u, d, input logic [3:0] a, b, c,
                       input logic [2:0] w, input int hold);
    btn_up = u;
    btn_down = d;
    push({tag, ".pre"}, e0, e1, e2, 3'b000);
    tick(5);
    pop_check();
    push({tag, ".edge6"}, a, b, c, w);
    tick(1);
    pop_check();
    e0 = a; e1 = b; e2 = c;
    push({tag, ".after"}, e0, e1, e2, 3'b000);
    tick(1 + hold);
    pop_check();
    btn_up = 1'b0;
    btn_down = 1'b0;
    push({tag, ".released"}, e0, e1, e2, 3'b000);
    tick(10);
    pop_check();
  endtask

  task automatic do_load(input string tag, input logic [3:0] v, input logic [3:0] a, b, c);
    load = 1'b1;
    load_value = v;
    push(tag, a, b, c, 3'b000);
    tick(1);
    load = 1'b0;
    pop_check();
    e0 = a; e1 = b; e2 = c;
  endtask

  initial begin
    tick(2);
    push("reset", 4'd0, 4'd0, 4'd0, 3'b000);
    pop_check();
    reset = 1'b0;
    press("up_hold", 1'b1, 1'b0, 4'd1, 4'd1, 4'd1, 3'b000, 13);
    btn_up = 1'b1;
    tick(3);
    btn_up = 1'b0;
    push("glitch", e0, e1, e2, 3'b000);
    tick(10);
    pop_check();
    do_load("load15", 4'd15, 4'd15, 4'd15, 4'd10);
    press("up_at_max", 1'b1, 1'b0, 4'd0, 4'd15, 4'd0, 3'b101, 0);
    press("down_sat", 1'b0, 1'b1, 4'd15, 4'd14, 4'd10, 3'b101, 0);
    do_load("load0", 4'd0, 4'd0, 4'd0, 4'd0);
    press("both", 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 0);
    press("down_at_min", 1'b0, 1'b1, 4'd15, 4'd0, 4'd10, 3'b101, 0);
    btn_up = 1'b1;
    tick(5);
    do_load("load_vs_up", 4'd9, 4'd9, 4'd9, 4'd9);
    push("load_vs_up.hold", 4'd9, 4'd9, 4'd9, 3'b000);
    tick(1);
    pop_check();
    btn_up = 1'b0;
    tick(10);
    do_load("load13", 4'd13, 4'd13, 4'd13, 4'd10);
    btn_up = 1'b1;
    tick(2);
    reset = 1'b1;
    push("mid_reset", 4'd0, 4'd0, 4'd0, 3'b000);
    tick(1);
    pop_check();
    reset = 1'b0;
    e0 = '0; e1 = '0; e2 = '0;
    press("held_after_reset", 1'b1, 1'b0, 4'd1, 4'd1, 4'd1, 3'b000, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/button_counter_gen.md
Name: button_counter_gen

Overview:
Parametrised up/down event counter driven by two mechanical push-buttons.
Each button input is synchronised and debounced. Each qualified press (debounced rising edge) steps the count once.
Supports configurable width and terminal value, wrap or saturate mode, a synchronous parallel load, and terminal-status flags.
Sits in the supportive_modules board-I/O layer between raw FPGA button pins and display or test-control logic.

Parameters:
WIDTH, 4, counter width in bits (>=1)
MAX_VALUE, 2**WIDTH-1, terminal count; must be <= 2**WIDTH-1
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a level change (>=1)
SATURATE, 0, 0 = wrap at the ends; 1 = clamp at 0 and MAX_VALUE
REPEAT_CYCLES, 8, auto-repeat interval in cycles (used only with AUTO_REPEAT_EN)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
btn_up  input  1  raw asynchronous button, increments count
btn_down  input  1  raw asynchronous button, decrements count
load  input  1  synchronous load strobe
load_value  input  WIDTH  value to load; values above MAX_VALUE are clamped to MAX_VALUE
count  output  WIDTH  current count (registered)
at_max  output  1  count == MAX_VALUE (combinational decode of count)
at_min  output  1  count == 0 (combinational decode of count)
wrap_pulse  output  1  registered one-cycle pulse on a wrap in either direction

Behaviour:
- Reset (synchronous, active-high; clk and reset naming fixed):
  - count=0, wrap_pulse=0, at_min=1, at_max=(MAX_VALUE==0).
  - All synchronisers, debounce state and stability counters clear to 0.
- Per-button path (up and down identical and independent):
  - 2-flop synchroniser produces s2.
  - Debounced level db plus stability counter stab, width ceil(log2(DEBOUNCE_CYCLES+1)).
  - If s2==db: stab<=0.
  - Else if stab==DEBOUNCE_CYCLES-1: db<=s2, stab<=0.
  - Else: stab<=stab+1.
- Press event: asserted on the edge where db goes 0->1.
  - Latency: count changes on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the button high as the 1st.
  - Exactly one event per press however long it is held (auto-repeat excepted).
  - Releases produce no event.
  - Glitches shorter than DEBOUNCE_CYCLES synchronised cycles are ignored.
- Count update priority, evaluated each edge:
  1. reset.
  2. load: count<=min(load_value, MAX_VALUE); pending press events this cycle are discarded; wrap_pulse<=0.
  3. Up and down events on the same edge cancel: no change, wrap_pulse<=0.
  4. Up event:
     - count<MAX_VALUE: count+1.
     - At MAX_VALUE with SATURATE=0: count<=0 and wrap_pulse<=1.
     - At MAX_VALUE with SATURATE=1: hold, no pulse.
  5. Down event:
     - count>0: count-1.
     - At 0 with SATURATE=0: count<=MAX_VALUE and wrap_pulse<=1.
     - At 0 with SATURATE=1: hold.
  6. Otherwise: hold, wrap_pulse<=0.
- Arithmetic stays within WIDTH bits. MAX_VALUE compares are unsigned; no value outside 0..MAX_VALUE is ever reached.
- Reset mid-debounce discards the partial press. A button still held after reset deasserts counts as a new press once debounced.

Optional Feature:
AUTO_REPEAT_EN
- Defined:
  - Each button gets a repeat timer that clears on the press event.
  - While db stays 1, it generates an additional event every REPEAT_CYCLES cycles after the initial press event.
  - Repeat events follow the same priority, cancel, saturate and wrap rules.
  - Release (db 1->0) or reset stops repeat immediately.
- Undefined: no repeat timer logic is synthesised; exactly one event per press.

Test Plan:
- Defaults; btn_up held high 20 cycles from idle -> count 0->1 on the 6th edge, stays 1 throughout; at_min falls the same cycle.
- btn_up high for 3 cycles, then low -> count remains 0, no wrap_pulse.
- SATURATE=0, load_value=15, load=1 one cycle, then one up press -> count 15, then 0, wrap_pulse high for exactly one cycle. Repeat with SATURATE=1 -> count stays 15, wrap_pulse 0. Then one down press -> 14.
- From count=0, btn_up and btn_down pressed in the same cycle (both debounce together) -> count stays 0. A down press alone with SATURATE=0 -> count 15, wrap_pulse=1.
- load=1 with load_value=9 on the same edge as an up event -> count 9. MAX_VALUE=10, load_value=13 -> count 10, at_max=1.
- reset asserted 2 cycles into a btn_up debounce, then released with the button still held -> all outputs at reset values; count 0->1 on the 6th edge after reset deasserts. With AUTO_REPEAT_EN, REPEAT_CYCLES=8, 30-cycle hold -> count 0->1, then +1 every 8 cycles.
